// File: rtl/acct_checker.sv
// Access-control enforcement stage: checks each request against its permission nibble,
// forwards or denies it, and logs violations. Optional macro: ACCT_CHK_MMODE_OVERRIDE_EN.
module acct_checker #(
  parameter int NB_MASTER = 3,
  parameter int NB_PERIPH = 24,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int CNT_W     = 16,
  localparam int MW = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1,
  localparam int PW = (NB_PERIPH > 1) ? $clog2(NB_PERIPH) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NB_MASTER-1:0][4*NB_PERIPH-1:0] acc_ctrl_i,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic [MW-1:0]                         req_master_i,
  input  logic [PW-1:0]                         req_periph_i,
  input  logic [1:0]                            req_priv_i,
  input  logic                                  req_we_i,
  input  logic [ADDR_W-1:0]                     req_addr_i,
  input  logic [DATA_W-1:0]                     req_wdata_i,
  output logic                                  fwd_valid_o,
  input  logic                                  fwd_ready_i,
  output logic                                  fwd_we_o,
  output logic [ADDR_W-1:0]                     fwd_addr_o,
  output logic [DATA_W-1:0]                     fwd_wdata_o,
  output logic                                  deny_valid_o,
  input  logic                                  deny_ready_i,
  input  logic                                  viol_clr_i,
  output logic [CNT_W-1:0]                      viol_cnt_o,
  output logic                                  viol_valid_o,
  output logic [ADDR_W-1:0]                     viol_addr_o,
  output logic [7:0]                            viol_info_o,
  output logic                                  irq_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] FWD   = 2'd2;
  localparam logic [1:0] DENY  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [MW-1:0]     master_q, master_d;
  logic [PW-1:0]     periph_q, periph_d;
  logic [1:0]        priv_q, priv_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              vvalid_q, vvalid_d;
  logic [ADDR_W-1:0] vaddr_q, vaddr_d;
  logic [7:0]        vinfo_q, vinfo_d;

  logic       hit;
  logic [3:0] nibble;
  logic       permit;
  logic       viol_event;

  // Out-of-range indices never match the select loop, so they fall through to deny.
  always_comb begin
    hit    = 1'b0;
    nibble = 4'h0;
    for (int m = 0; m < NB_MASTER; m++) begin
      for (int p = 0; p < NB_PERIPH; p++) begin
        if (master_q == MW'(m) && periph_q == PW'(p)) begin
          hit    = 1'b1;
          nibble = acc_ctrl_i[m][4*p +: 4];
        end
      end
    end
    permit = hit && (priv_q != 2'd2) && nibble[priv_q];
`ifdef ACCT_CHK_MMODE_OVERRIDE_EN
    if (hit && priv_q == 2'd3) permit = 1'b1;
`endif
  end

  assign viol_event = (state_q == CHECK) && !permit;

  always_comb begin
    state_d  = state_q;
    master_d = master_q;
    periph_d = periph_q;
    priv_d   = priv_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          master_d = req_master_i;
          periph_d = req_periph_i;
          priv_d   = req_priv_i;
          we_d     = req_we_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          state_d  = CHECK;
        end
      end
      CHECK:   state_d = permit ? FWD : DENY;
      FWD:     if (fwd_ready_i) state_d = IDLE;
      DENY:    if (deny_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A violation in the same cycle as a clear restarts the log with that violation.
  always_comb begin
    cnt_d    = cnt_q;
    vvalid_d = vvalid_q;
    vaddr_d  = vaddr_q;
    vinfo_d  = vinfo_q;
    if (viol_event) begin
      if (viol_clr_i)       cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
      else if (~&cnt_q)     cnt_d = cnt_q + 1'b1;
      if (viol_clr_i || !vvalid_q) begin
        vvalid_d = 1'b1;
        vaddr_d  = addr_q;
        vinfo_d  = {2'(master_q), priv_q, we_q, 3'b000};
      end
    end else if (viol_clr_i) begin
      cnt_d    = '0;
      vvalid_d = 1'b0;
      vaddr_d  = '0;
      vinfo_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      master_q <= '0;
      periph_q <= '0;
      priv_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      vvalid_q <= 1'b0;
      vaddr_q  <= '0;
      vinfo_q  <= '0;
    end else begin
      state_q  <= state_d;
      master_q <= master_d;
      periph_q <= periph_d;
      priv_q   <= priv_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      vvalid_q <= vvalid_d;
      vaddr_q  <= vaddr_d;
      vinfo_q  <= vinfo_d;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign fwd_valid_o  = (state_q == FWD);
  assign deny_valid_o = (state_q == DENY);
  assign fwd_we_o     = we_q;
  assign fwd_addr_o   = addr_q;
  assign fwd_wdata_o  = wdata_q;
  assign viol_cnt_o   = cnt_q;
  assign viol_valid_o = vvalid_q;
  assign viol_addr_o  = vaddr_q;
  assign viol_info_o  = vinfo_q;
  assign irq_o        = vvalid_q;

endmodule

// File: tb/tb_acct_checker.sv
// Directed bench for acct_checker; counter width reduced to 4 so saturation is reachable.
module tb_acct_checker;

  localparam int NB_MASTER = 3;
  localparam int NB_PERIPH = 24;
  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 64;
  localparam int CNT_W     = 4;

  logic                                  clk;
  logic                                  rst_n;
  logic [NB_MASTER-1:0][4*NB_PERIPH-1:0] acc;
  logic                                  req_valid;
  logic                                  req_ready;
  logic [1:0]                            req_master;
  logic [4:0]                            req_periph;
  logic [1:0]                            req_priv;
  logic                                  req_we;
  logic [ADDR_W-1:0]                     req_addr;
  logic [DATA_W-1:0]                     req_wdata;
  logic                                  fwd_valid;
  logic                                  fwd_ready;
  logic                                  fwd_we;
  logic [ADDR_W-1:0]                     fwd_addr;
  logic [DATA_W-1:0]                     fwd_wdata;
  logic                                  deny_valid;
  logic                                  deny_ready;
  logic                                  viol_clr;
  logic [CNT_W-1:0]                      viol_cnt;
  logic                                  viol_valid;
  logic [ADDR_W-1:0]                     viol_addr;
  logic [7:0]                            viol_info;
  logic                                  irq;

  int vecs = 0;
  int errs = 0;

  acct_checker #(
    .NB_MASTER(NB_MASTER), .NB_PERIPH(NB_PERIPH), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .acc_ctrl_i(acc),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_master_i(req_master), .req_periph_i(req_periph), .req_priv_i(req_priv),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .fwd_valid_o(fwd_valid), .fwd_ready_i(fwd_ready), .fwd_we_o(fwd_we),
    .fwd_addr_o(fwd_addr), .fwd_wdata_o(fwd_wdata),
    .deny_valid_o(deny_valid), .deny_ready_i(deny_ready),
    .viol_clr_i(viol_clr), .viol_cnt_o(viol_cnt), .viol_valid_o(viol_valid),
    .viol_addr_o(viol_addr), .viol_info_o(viol_info), .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds req_valid for one edge; returns #1 into the CHECK cycle.
  task automatic issue(input logic [1:0] m, input logic [4:0] p, input logic [1:0] pv,
                       input logic we, input logic [ADDR_W-1:0] a);
    req_master = m; req_periph = p; req_priv = pv; req_we = we;
    req_addr = a; req_wdata = {a[31:0], 32'hA5A5_5A5A};
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic finish_txn();
    fwd_ready = 1'b1; deny_ready = 1'b1;
    @(posedge clk); #1;
    fwd_ready = 1'b0; deny_ready = 1'b0;
  endtask

  task automatic clr_pulse();
    viol_clr = 1'b1;
    @(posedge clk); #1;
    viol_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if (req_ready !== 1'b1 || fwd_valid !== 1'b0 || deny_valid !== 1'b0 || irq !== 1'b0 ||
        viol_cnt !== '0 || viol_valid !== 1'b0 || fwd_addr !== '0) begin
      errs++;
      $display("FAIL reset_state: rdy=%b fwd=%b deny=%b cnt=%0d vv=%b irq=%b addr=%h required rdy=1 others 0",
               req_ready, fwd_valid, deny_valid, viol_cnt, viol_valid, irq, fwd_addr);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    issue(2'd0, 5'd5, 2'd0, 1'b0, 64'h1800_0000);
    vecs++;
    if (req_ready !== 1'b0 || fwd_valid !== 1'b0) begin
      errs++;
      $display("FAIL fwd_check_cycle: rdy=%b fwd=%b required 0 0", req_ready, fwd_valid);
    end
    @(posedge clk); #1;
    vecs++;
    if (fwd_valid !== 1'b1 || deny_valid !== 1'b0 || fwd_addr !== 64'h1800_0000 || fwd_we !== 1'b0) begin
      errs++;
      $display("FAIL fwd_at_n2: fwd=%b deny=%b addr=%h we=%b required 1 0 1800_0000 0",
               fwd_valid, deny_valid, fwd_addr, fwd_we);
    end
    finish_txn();
    vecs++;
    if (req_ready !== 1'b1 || fwd_valid !== 1'b0 || viol_cnt !== 4'd0) begin
      errs++;
      $display("FAIL fwd_done: rdy=%b fwd=%b cnt=%0d required 1 0 0", req_ready, fwd_valid, viol_cnt);
    end
  endtask

  task automatic test_deny();
    acc[1][4*2 +: 4] = 4'b1000;
    issue(2'd1, 5'd2, 2'd1, 1'b1, 64'h4000);
    @(posedge clk); #1;
    vecs++;
    if (deny_valid !== 1'b1 || fwd_valid !== 1'b0 || viol_cnt !== 4'd1 || viol_addr !== 64'h4000 ||
        viol_info !== 8'b01_01_1_000 || irq !== 1'b1 || viol_valid !== 1'b1) begin
      errs++;
      $display("FAIL deny_first: deny=%b fwd=%b cnt=%0d addr=%h info=%b irq=%b required 1 0 1 4000 01011000 1",
               deny_valid, fwd_valid, viol_cnt, viol_addr, viol_info, irq);
    end
    finish_txn();
    issue(2'd1, 5'd2, 2'd1, 1'b1, 64'h5000);
    @(posedge clk); #1;
    vecs++;
    if (deny_valid !== 1'b1 || viol_cnt !== 4'd2 || viol_addr !== 64'h4000) begin
      errs++;
      $display("FAIL deny_second: deny=%b cnt=%0d addr=%h required 1 2 4000", deny_valid, viol_cnt, viol_addr);
    end
    finish_txn();
    issue(2'd1, 5'd2, 2'd1, 1'b1, 64'h6000);
    viol_clr = 1'b1;
    @(posedge clk); #1;
    viol_clr = 1'b0;
    vecs++;
    if (deny_valid !== 1'b1 || viol_cnt !== 4'd1 || viol_addr !== 64'h6000 || viol_valid !== 1'b1) begin
      errs++;
      $display("FAIL clr_vs_viol: deny=%b cnt=%0d addr=%h vv=%b required 1 1 6000 1",
               deny_valid, viol_cnt, viol_addr, viol_valid);
    end
    finish_txn();
    clr_pulse();
    vecs++;
    if (viol_cnt !== 4'd0 || viol_valid !== 1'b0 || viol_addr !== '0 || viol_info !== 8'h00 || irq !== 1'b0) begin
      errs++;
      $display("FAIL clr_alone: cnt=%0d vv=%b addr=%h info=%h irq=%b required all 0",
               viol_cnt, viol_valid, viol_addr, viol_info, irq);
    end
  endtask

  task automatic test_always_deny();
    logic [1:0] mv [3];
    logic [4:0] pv [3];
    logic [1:0] rv [3];
    acc = '1;
    mv[0] = 2'd0; pv[0] = 5'd30; rv[0] = 2'd0;
    mv[1] = 2'd0; pv[1] = 5'd0;  rv[1] = 2'd2;
    mv[2] = 2'd3; pv[2] = 5'd0;  rv[2] = 2'd3;
    for (int i = 0; i < 3; i++) begin
      issue(mv[i], pv[i], rv[i], 1'b0, 64'h7000 + 64'(i));
      @(posedge clk); #1;
      vecs++;
      if (deny_valid !== 1'b1 || fwd_valid !== 1'b0 || viol_cnt !== 4'(i + 1) || viol_addr !== 64'h7000) begin
        errs++;
        $display("FAIL always_deny_%0d: deny=%b fwd=%b cnt=%0d addr=%h required 1 0 %0d 7000",
                 i, deny_valid, fwd_valid, viol_cnt, viol_addr, i + 1);
      end
      finish_txn();
    end
  endtask

  task automatic test_saturate();
    clr_pulse();
    for (int i = 0; i < 16; i++) begin
      issue(2'd0, 5'd30, 2'd0, 1'b0, 64'h9000 + 64'(i));
      @(posedge clk); #1;
      finish_txn();
      if (i == 14) begin
        vecs++;
        if (viol_cnt !== 4'hF) begin
          errs++;
          $display("FAIL sat_reach: cnt=%h required F", viol_cnt);
        end
      end
    end
    vecs++;
    if (viol_cnt !== 4'hF || viol_addr !== 64'h9000) begin
      errs++;
      $display("FAIL sat_hold: cnt=%h addr=%h required F 9000", viol_cnt, viol_addr);
    end
    clr_pulse();
  endtask

  task automatic test_ctrl_change();
    acc = '1;
    issue(2'd0, 5'd1, 2'd0, 1'b0, 64'hA000);
    acc[0][4*1 +: 4] = 4'h0;
    @(posedge clk); #1;
    vecs++;
    if (deny_valid !== 1'b1 || fwd_valid !== 1'b0 || viol_cnt !== 4'd1) begin
      errs++;
      $display("FAIL change_in_check: deny=%b fwd=%b cnt=%0d required 1 0 1", deny_valid, fwd_valid, viol_cnt);
    end
    finish_txn();
    acc = '1;
    issue(2'd0, 5'd1, 2'd0, 1'b0, 64'hB000);
    @(posedge clk); #1;
    acc[0][4*1 +: 4] = 4'h0;
    @(posedge clk); #1;
    vecs++;
    if (fwd_valid !== 1'b1 || deny_valid !== 1'b0 || fwd_addr !== 64'hB000 || viol_cnt !== 4'd1) begin
      errs++;
      $display("FAIL change_in_fwd: fwd=%b deny=%b addr=%h cnt=%0d required 1 0 B000 1",
               fwd_valid, deny_valid, fwd_addr, viol_cnt);
    end
    finish_txn();
    acc = '1;
  endtask

  task automatic test_back_to_back();
    fwd_ready = 1'b1;
    issue(2'd2, 5'd3, 2'd1, 1'b1, 64'hC000);
    @(posedge clk); #1;
    vecs++;
    if (fwd_valid !== 1'b1 || fwd_addr !== 64'hC000 || fwd_we !== 1'b1) begin
      errs++;
      $display("FAIL b2b_first: fwd=%b addr=%h we=%b required 1 C000 1", fwd_valid, fwd_addr, fwd_we);
    end
    @(posedge clk); #1;
    vecs++;
    if (req_ready !== 1'b1 || fwd_valid !== 1'b0) begin
      errs++;
      $display("FAIL b2b_idle: rdy=%b fwd=%b required 1 0", req_ready, fwd_valid);
    end
    issue(2'd2, 5'd4, 2'd3, 1'b0, 64'hD000);
    @(posedge clk); #1;
    vecs++;
    if (fwd_valid !== 1'b1 || fwd_addr !== 64'hD000 || fwd_wdata !== 64'h0000_D000_A5A5_5A5A) begin
      errs++;
      $display("FAIL b2b_second: fwd=%b addr=%h wdata=%h required 1 D000 0000D000A5A55A5A",
               fwd_valid, fwd_addr, fwd_wdata);
    end
    @(posedge clk); #1;
    fwd_ready = 1'b0;
  endtask

  task automatic test_mmode();
    acc[2][4*7 +: 4] = 4'h0;
    issue(2'd2, 5'd7, 2'd3, 1'b0, 64'hE000);
    @(posedge clk); #1;
    vecs++;
`ifdef ACCT_CHK_MMODE_OVERRIDE_EN
    if (fwd_valid !== 1'b1 || deny_valid !== 1'b0 || viol_cnt !== 4'd1) begin
      errs++;
      $display("FAIL mmode_override: fwd=%b deny=%b cnt=%0d required 1 0 1", fwd_valid, deny_valid, viol_cnt);
    end
`else
    if (deny_valid !== 1'b1 || fwd_valid !== 1'b0 || viol_cnt !== 4'd2) begin
      errs++;
      $display("FAIL mmode_checked: deny=%b fwd=%b cnt=%0d required 1 0 2", deny_valid, fwd_valid, viol_cnt);
    end
`endif
    finish_txn();
    acc = '1;
  endtask

  task automatic test_reset_mid();
    issue(2'd0, 5'd0, 2'd0, 1'b0, 64'hF000);
    @(posedge clk); #1;
    vecs++;
    if (fwd_valid !== 1'b1) begin
      errs++;
      $display("FAIL rst_mid_pre: fwd=%b required 1", fwd_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if (fwd_valid !== 1'b0 || req_ready !== 1'b1 || viol_cnt !== 4'd0) begin
      errs++;
      $display("FAIL rst_mid_async: fwd=%b rdy=%b cnt=%0d required 0 1 0", fwd_valid, req_ready, viol_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vecs++;
    if (req_ready !== 1'b1 || fwd_valid !== 1'b0 || deny_valid !== 1'b0 || viol_cnt !== 4'd0 || viol_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_mid_after: rdy=%b fwd=%b deny=%b cnt=%0d vv=%b required 1 0 0 0 0",
               req_ready, fwd_valid, deny_valid, viol_cnt, viol_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0; acc = '1; req_valid = 1'b0; req_master = '0; req_periph = '0;
    req_priv = '0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    fwd_ready = 1'b0; deny_ready = 1'b0; viol_clr = 1'b0;
    test_reset();
    test_forward();
    test_deny();
    test_always_deny();
    test_saturate();
    test_ctrl_change();
    test_back_to_back();
    test_mmode();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
